// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch slice.
// Word/address typedefs, reset PC, PC step, NOP and the IF/ID bundle.
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  localparam addr_t RESET_PC_DEF = 32'h0000_0000;
  localparam int    PC_STEP_DEF  = 4;
  localparam word_t NOP          = 32'h0000_0000;

  typedef struct packed {
    logic  valid;
    word_t inst;
    addr_t pc4;
  } if_id_t;

  function automatic addr_t align(addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: ROM port, redirect inputs and IF/ID handshake.
// master = fetch stage, slave = ROM/decode/execute side.
interface fetch_unit_if;
  import cpu_pkg::*;

  addr_t Inst_Addr;
  word_t Inst_In;
  logic  Br_Taken;
  addr_t Br_Target;
  logic  Jmp;
  addr_t Jmp_Target;
  logic  Id_Ready;
  logic  Id_Valid;
  word_t Id_Inst;
  addr_t Id_PC4;

  modport master (
    output Inst_Addr, Id_Valid, Id_Inst, Id_PC4,
    input  Inst_In, Br_Taken, Br_Target,
    input  Jmp, Jmp_Target, Id_Ready
  );

  modport slave (
    input  Inst_Addr, Id_Valid, Id_Inst, Id_PC4,
    output Inst_In, Br_Taken, Br_Target,
    output Jmp, Jmp_Target, Id_Ready
  );

endinterface

// File: rtl/fetch_unit_npc_sel.sv
// Next-PC and IF/ID load/flush select for the fetch stage.
// Branch (older) beats jump, which beats sequential advance.
module npc_sel
  import cpu_pkg::*;
#(
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  addr_t pc,
  input  logic  br_taken,
  input  addr_t br_target,
  input  logic  jmp,
  input  addr_t jmp_target,
  input  logic  id_valid,
  input  logic  id_ready,
  output addr_t npc,
  output logic  ld_pc,
  output logic  ld_ifid,
  output logic  flush
);

  logic adv;
  logic sel_br;
  logic sel_jmp;
  logic sel_adv;

  assign adv     = !id_valid || id_ready;
  assign sel_br  = br_taken;
  assign sel_jmp = jmp && !br_taken;
  assign sel_adv = adv && !br_taken && !jmp;

  always_comb begin
    npc     = pc;
    ld_pc   = 1'b0;
    ld_ifid = 1'b0;
    flush   = 1'b0;
    unique case (1'b1)
      sel_br: begin
        npc   = align(br_target);
        ld_pc = 1'b1;
        flush = 1'b1;
      end
      sel_jmp: begin
        npc   = align(jmp_target);
        ld_pc = 1'b1;
        flush = 1'b1;
      end
      sel_adv: begin
        npc     = pc + addr_t'(PC_STEP);
        ld_pc   = 1'b1;
        ld_ifid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, drives ROM address, fills IF/ID register.
// Optional FETCH_PERF_EN adds transfer/flush counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEF,
  parameter int    PC_STEP  = PC_STEP_DEF
) (
  input  logic          Clk,
  input  logic          Clrn,
  fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output word_t         Perf_Fetch,
  output word_t         Perf_Flush
`endif
);

  addr_t  pc;
  addr_t  npc;
  if_id_t ifid;
  logic   ld_pc;
  logic   ld_ifid;
  logic   flush;

  npc_sel #(
    .PC_STEP (PC_STEP)
  ) u_npc_sel (
    .pc         (pc),
    .br_taken   (bus.Br_Taken),
    .br_target  (bus.Br_Target),
    .jmp        (bus.Jmp),
    .jmp_target (bus.Jmp_Target),
    .id_valid   (ifid.valid),
    .id_ready   (bus.Id_Ready),
    .npc        (npc),
    .ld_pc      (ld_pc),
    .ld_ifid    (ld_ifid),
    .flush      (flush)
  );

  // On advance npc is PC+step, which is exactly the captured PC+4.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pc   <= RESET_PC;
      ifid <= '{valid: 1'b0, inst: NOP, pc4: '0};
    end else begin
      if (ld_pc)
        pc <= npc;
      if (flush)
        ifid.valid <= 1'b0;
      else if (ld_ifid)
        ifid <= '{valid: 1'b1, inst: bus.Inst_In, pc4: npc};
    end
  end

  assign bus.Inst_Addr = pc;
  assign bus.Id_Valid  = ifid.valid;
  assign bus.Id_Inst   = ifid.inst;
  assign bus.Id_PC4    = ifid.pc4;

`ifdef FETCH_PERF_EN
  word_t fetch_q;
  word_t flush_q;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      if (ifid.valid && bus.Id_Ready)
        fetch_q <= fetch_q + 32'd1;
      if (bus.Br_Taken || bus.Jmp)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign Perf_Fetch = fetch_q;
  assign Perf_Flush = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an IF/ID scoreboard.
// Also checks perf counters when FETCH_PERF_EN is defined.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct {
    word_t inst;
    addr_t pc4;
  } exp_t;

  logic  clk = 1'b0;
  logic  clrn;
  word_t rom [32];
  exp_t  q [$];
  addr_t mpc;
  logic  mvalid;
  word_t mfetch;
  word_t mflush;
  int    nvec = 0;
  int    nerr = 0;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  word_t perf_fetch;
  word_t perf_flush;
`endif

  fetch_unit dut (
    .Clk  (clk),
    .Clrn (clrn),
    .bus  (bus)
`ifdef FETCH_PERF_EN
    ,
    .Perf_Fetch (perf_fetch),
    .Perf_Flush (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  assign bus.Inst_In = rom[bus.Inst_Addr[6:2]];

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at a negedge, check, then model the next rising edge.
  task automatic cyc(input logic br, input addr_t bt,
                     input logic j, input addr_t jt, input logic rdy);
    exp_t e;
    bus.Br_Taken   = br;
    bus.Br_Target  = bt;
    bus.Jmp        = j;
    bus.Jmp_Target = jt;
    bus.Id_Ready   = rdy;
    #1;
    chk("addr", bus.Inst_Addr, mpc);
    chk("valid", 32'(bus.Id_Valid), 32'(mvalid));
    if (mvalid) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $error("FAIL sb_empty observed=valid expected=no entry");
      end else begin
        chk("sb_inst", bus.Id_Inst, q[0].inst);
        chk("sb_pc4", bus.Id_PC4, q[0].pc4);
        if (rdy)
          void'(q.pop_front());
      end
    end
    if (mvalid && rdy)
      mfetch++;
    if (br || j)
      mflush++;
    if (br) begin
      q.delete();
      mpc    = {bt[31:2], 2'b00};
      mvalid = 1'b0;
    end else if (j) begin
      q.delete();
      mpc    = {jt[31:2], 2'b00};
      mvalid = 1'b0;
    end else if (!mvalid || rdy) begin
      e.inst = rom[mpc[6:2]];
      e.pc4  = mpc + 32'd4;
      q.push_back(e);
      mpc    = mpc + 32'd4;
      mvalid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      rom[i] = 32'h1000_0000 + i * 32'h0001_0101;
    clrn           = 1'b0;
    bus.Br_Taken   = 1'b0;
    bus.Br_Target  = '0;
    bus.Jmp        = 1'b0;
    bus.Jmp_Target = '0;
    bus.Id_Ready   = 1'b0;
    mpc    = 32'h0;
    mvalid = 1'b0;
    mfetch = '0;
    mflush = '0;
    #1;
    chk("rst_valid", 32'(bus.Id_Valid), 32'h0);
    chk("rst_inst", bus.Id_Inst, 32'h0);
    chk("rst_pc4", bus.Id_PC4, 32'h0);
    chk("rst_addr", bus.Inst_Addr, 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    cyc(0, 0, 0, 0, 1);
    chk("seq_addr4", bus.Inst_Addr, 32'h4);
    chk("seq_instA", bus.Id_Inst, rom[0]);
    chk("seq_pc4A", bus.Id_PC4, 32'h4);
    cyc(0, 0, 0, 0, 1);
    chk("seq_addr8", bus.Inst_Addr, 32'h8);
    chk("seq_instB", bus.Id_Inst, rom[1]);
    chk("seq_pc4B", bus.Id_PC4, 32'h8);

    repeat (3) begin
      cyc(0, 0, 0, 0, 0);
      chk("stall_addr", bus.Inst_Addr, 32'h8);
      chk("stall_inst", bus.Id_Inst, rom[1]);
      chk("stall_valid", 32'(bus.Id_Valid), 32'h1);
    end
    cyc(0, 0, 0, 0, 1);
    chk("rel_instC", bus.Id_Inst, rom[2]);
    chk("rel_pc4C", bus.Id_PC4, 32'hC);
    chk("seq_addrC", bus.Inst_Addr, 32'hC);
    cyc(0, 0, 0, 0, 1);

    cyc(1, 32'h40, 0, 0, 0);
    chk("br_addr", bus.Inst_Addr, 32'h40);
    chk("br_bubble", 32'(bus.Id_Valid), 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("br_inst", bus.Id_Inst, rom[16]);
    chk("br_pc4", bus.Id_PC4, 32'h44);

    cyc(1, 32'h20, 1, 32'h60, 1);
    chk("br_over_jmp", bus.Inst_Addr, 32'h20);
    cyc(0, 0, 1, 32'h63, 1);
    chk("jmp_align", bus.Inst_Addr, 32'h60);
    cyc(0, 0, 0, 0, 1);

    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_pre", bus.Inst_Addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_addr", bus.Inst_Addr, 32'h0);
    chk("wrap_pc4", bus.Id_PC4, 32'h0);
    chk("wrap_inst", bus.Id_Inst, rom[31]);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);

`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, mfetch);
    chk("perf_flush", perf_flush, mflush);
`endif

    #3;
    clrn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.Id_Valid), 32'h0);
    chk("arst_addr", bus.Inst_Addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("arst_pfetch", perf_fetch, 32'h0);
    chk("arst_pflush", perf_flush, 32'h0);
`endif
    q.delete();
    mpc    = 32'h0;
    mvalid = 1'b0;
    mfetch = '0;
    mflush = '0;
    @(negedge clk);
    clrn = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 1);
    chk("restart_inst", bus.Id_Inst, rom[2]);
    chk("restart_pc4", bus.Id_PC4, 32'hC);
    cyc(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
